// File: rtl/counter_updown_mod_if.sv
// Bus between a counter_updown_mod stage and its user.
// Carries load/enable/direction controls, the count state, the terminal count and the wrap pulse.
interface counter_updown_mod_if #(
    parameter int unsigned WIDTH = 12
);
    logic             load;
    logic [WIDTH-1:0] d;
    logic             cep;
    logic             cet;
    logic             up;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output load, d, cep, cet, up,
        input  q, tc, wrap
    );

    modport slave (
        input  load, d, cep, cet, up,
        output q, tc, wrap
    );
endinterface

// File: rtl/counter_updown_mod.sv
// Presettable modulo-N up/down counter with dual enables, a cascadable terminal count
// and a registered wrap pulse. Priority on each clock edge: clr, then load, then count, then hold.
module counter_updown_mod #(
    parameter int unsigned      WIDTH   = 12,
    parameter longint unsigned  MODULUS = 4096
) (
    input  logic                  clk,
    input  logic                  clr,
    counter_updown_mod_if.slave   bus
);
    // Largest reachable count; MODULUS may equal 2**WIDTH, so take MODULUS-1 in 64 bits first.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_r;
    logic             wrap_nxt;

    // Next-state selection for load, count and hold.
    always_comb begin
        q_nxt    = q_r;
        wrap_nxt = 1'b0;
        if (bus.load) begin
            q_nxt = (bus.d > MAX_Q) ? MAX_Q : bus.d;
        end else if (bus.cep && bus.cet) begin
            if (bus.up) begin
                if (q_r >= MAX_Q) begin
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = q_r + WIDTH'(1);
                end
            end else begin
                if (q_r == '0) begin
                    q_nxt    = MAX_Q;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = q_r - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            wrap_r <= wrap_nxt;
        end
    end

    assign bus.q    = q_r;
    assign bus.wrap = wrap_r;
    // Zero-cycle path so a following stage's cet sees this stage's terminal state.
    assign bus.tc   = bus.cet & (bus.up ? (q_r == MAX_Q) : (q_r == '0));
endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed self-checking bench for counter_updown_mod: a 12-bit default stage,
// a 4-bit modulo-10 stage and a two-stage 4-bit cascade.
module tb_counter_updown_mod;
    logic clk;
    logic clr12;
    logic clr10;
    logic clrc;

    int total;
    int bad;

    counter_updown_mod_if #(.WIDTH(12)) if12 ();
    counter_updown_mod_if #(.WIDTH(4))  if10 ();
    counter_updown_mod_if #(.WIDTH(4))  ifc0 ();
    counter_updown_mod_if #(.WIDTH(4))  ifc1 ();

    counter_updown_mod #(.WIDTH(12), .MODULUS(4096)) dut12 (.clk(clk), .clr(clr12), .bus(if12));
    counter_updown_mod #(.WIDTH(4),  .MODULUS(10))   dut10 (.clk(clk), .clr(clr10), .bus(if10));
    counter_updown_mod #(.WIDTH(4),  .MODULUS(16))   dutc0 (.clk(clk), .clr(clrc),  .bus(ifc0));
    counter_updown_mod #(.WIDTH(4),  .MODULUS(16))   dutc1 (.clk(clk), .clr(clrc),  .bus(ifc1));

    // Second stage shares cep/up/load with the first and is enabled by its terminal count.
    assign ifc1.cet  = ifc0.tc;
    assign ifc1.cep  = ifc0.cep;
    assign ifc1.up   = ifc0.up;
    assign ifc1.load = ifc0.load;
    assign ifc1.d    = ifc0.d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr12 = 1'b1; clr10 = 1'b1; clrc = 1'b1;
        if12.load = 1'b0; if12.d = '0; if12.cep = 1'b1; if12.cet = 1'b1; if12.up = 1'b1;
        if10.load = 1'b0; if10.d = '0; if10.cep = 1'b1; if10.cet = 1'b1; if10.up = 1'b1;
        ifc0.load = 1'b0; ifc0.d = '0; ifc0.cep = 1'b0; ifc0.cet = 1'b1; ifc0.up = 1'b1;
        step();
        step();
        total++;
        if (if12.q !== 12'd0) begin bad++; $display("FAIL reset_q q=%0d want 0", if12.q); end
        total++;
        if (if12.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap wrap=%b want 0", if12.wrap); end
        total++;
        if (if12.tc !== 1'b0) begin bad++; $display("FAIL reset_tc tc=%b want 0", if12.tc); end
        total++;
        if (if10.q !== 4'd0) begin bad++; $display("FAIL reset_q10 q=%0d want 0", if10.q); end
        clr12 = 1'b0; clr10 = 1'b0; clrc = 1'b0;
        if12.cep = 1'b0; if10.cep = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (if12.q !== 12'd0) begin bad++; $display("FAIL idle_hold q=%0d want 0", if12.q); end
        end
    endtask

    task automatic test_full_up();
        int exp;
        exp = 0;
        if12.cep = 1'b1; if12.cet = 1'b1; if12.up = 1'b1;
        for (int i = 1; i <= 4096; i++) begin
            total++;
            if (if12.tc !== 1'(exp == 4095)) begin
                bad++; $display("FAIL up_tc q=%0d tc=%b want %b", if12.q, if12.tc, exp == 4095);
            end
            step();
            exp = (exp + 1) % 4096;
            total++;
            if (if12.q !== 12'(exp)) begin bad++; $display("FAIL up_q step=%0d q=%0d want %0d", i, if12.q, exp); end
            total++;
            if (if12.wrap !== 1'(i == 4096)) begin
                bad++; $display("FAIL up_wrap step=%0d wrap=%b want %b", i, if12.wrap, i == 4096);
            end
        end
        step();
        total++;
        if (if12.q !== 12'd1 || if12.wrap !== 1'b0) begin
            bad++; $display("FAIL up_after_wrap q=%0d wrap=%b want q=1 wrap=0", if12.q, if12.wrap);
        end
        if12.cep = 1'b0;
    endtask

    task automatic test_mod_down();
        int exp;
        int prev;
        exp = 0;
        if10.up = 1'b0; if10.cet = 1'b1; if10.cep = 1'b1;
        #1;
        total++;
        if (if10.tc !== 1'b1) begin bad++; $display("FAIL down_tc0 tc=%b want 1", if10.tc); end
        for (int i = 0; i < 11; i++) begin
            prev = exp;
            exp = (exp == 0) ? 9 : exp - 1;
            step();
            total++;
            if (if10.q !== 4'(exp)) begin bad++; $display("FAIL down_q step=%0d q=%0d want %0d", i, if10.q, exp); end
            total++;
            if (if10.wrap !== 1'(prev == 0)) begin
                bad++; $display("FAIL down_wrap step=%0d wrap=%b want %b", i, if10.wrap, prev == 0);
            end
            total++;
            if (if10.tc !== 1'(exp == 0)) begin
                bad++; $display("FAIL down_tc step=%0d tc=%b want %b", i, if10.tc, exp == 0);
            end
        end
        // Sequence ends at 9; step to 0 then check cet gating of tc.
        for (int i = 0; i < 9; i++) step();
        if10.cep = 1'b0; if10.cet = 1'b0;
        #1;
        total++;
        if (if10.q !== 4'd0 || if10.tc !== 1'b0) begin
            bad++; $display("FAIL down_tc_cet q=%0d tc=%b want q=0 tc=0", if10.q, if10.tc);
        end
    endtask

    task automatic test_load();
        if10.up = 1'b1; if10.cep = 1'b1; if10.cet = 1'b1;
        if10.load = 1'b1; if10.d = 4'd7;
        step();
        total++;
        if (if10.q !== 4'd7) begin bad++; $display("FAIL load_7 q=%0d want 7", if10.q); end
        if10.d = 4'd13;
        step();
        total++;
        if (if10.q !== 4'd9) begin bad++; $display("FAIL load_sat q=%0d want 9", if10.q); end
        // Load at the terminal state would otherwise wrap.
        if10.d = 4'd9;
        step();
        total++;
        if (if10.q !== 4'd9 || if10.wrap !== 1'b0) begin
            bad++; $display("FAIL load_no_wrap q=%0d wrap=%b want q=9 wrap=0", if10.q, if10.wrap);
        end
        clr10 = 1'b1; if10.d = 4'd5;
        step();
        total++;
        if (if10.q !== 4'd0 || if10.wrap !== 1'b0) begin
            bad++; $display("FAIL clr_over_load q=%0d wrap=%b want q=0 wrap=0", if10.q, if10.wrap);
        end
        // clr while counting at terminal: no wrap pulse.
        clr10 = 1'b0; if10.d = 4'd9;
        step();
        if10.load = 1'b0; clr10 = 1'b1;
        step();
        total++;
        if (if10.q !== 4'd0 || if10.wrap !== 1'b0) begin
            bad++; $display("FAIL clr_over_wrap q=%0d wrap=%b want q=0 wrap=0", if10.q, if10.wrap);
        end
        clr10 = 1'b0;
    endtask

    task automatic test_enables();
        if10.load = 1'b1; if10.d = 4'd9;
        step();
        if10.load = 1'b0; if10.cep = 1'b0; if10.cet = 1'b1; if10.up = 1'b1;
        step();
        total++;
        if (if10.q !== 4'd9 || if10.tc !== 1'b1) begin
            bad++; $display("FAIL cep_hold q=%0d tc=%b want q=9 tc=1", if10.q, if10.tc);
        end
        if10.cep = 1'b1; if10.cet = 1'b0;
        #1;
        total++;
        if (if10.tc !== 1'b0) begin bad++; $display("FAIL cet_tc tc=%b want 0", if10.tc); end
        step();
        total++;
        if (if10.q !== 4'd9 || if10.wrap !== 1'b0) begin
            bad++; $display("FAIL cet_hold q=%0d wrap=%b want q=9 wrap=0", if10.q, if10.wrap);
        end
        if10.load = 1'b1; if10.d = 4'd5;
        step();
        if10.load = 1'b0; if10.cet = 1'b1; if10.up = 1'b1;
        step();
        total++;
        if (if10.q !== 4'd6) begin bad++; $display("FAIL dir_up q=%0d want 6", if10.q); end
        if10.up = 1'b0;
        step();
        total++;
        if (if10.q !== 4'd5) begin bad++; $display("FAIL dir_down q=%0d want 5", if10.q); end
        if10.cep = 1'b0;
    endtask

    task automatic test_cascade();
        int exp;
        int wraps;
        clrc = 1'b1;
        step();
        clrc = 1'b0; ifc0.cep = 1'b1; ifc0.cet = 1'b1; ifc0.up = 1'b1; ifc0.load = 1'b0;
        exp = 0;
        wraps = 0;
        for (int i = 1; i <= 256; i++) begin
            step();
            exp = (exp + 1) % 256;
            total++;
            if ({ifc1.q, ifc0.q} !== 8'(exp)) begin
                bad++; $display("FAIL casc_q step=%0d q=%0d want %0d", i, {ifc1.q, ifc0.q}, exp);
            end
            total++;
            if (ifc0.wrap !== 1'((exp % 16) == 0)) begin
                bad++; $display("FAIL casc_wrap0 step=%0d wrap=%b want %b", i, ifc0.wrap, (exp % 16) == 0);
            end
            if (ifc1.wrap === 1'b1) wraps++;
        end
        total++;
        if (ifc1.wrap !== 1'b1 || wraps != 1) begin
            bad++; $display("FAIL casc_wrap1 wrap=%b count=%0d want wrap=1 count=1", ifc1.wrap, wraps);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_full_up();
        test_mod_down();
        test_load();
        test_enables();
        test_cascade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised synchronous binary counter, successor to the fixed 12-bit ripple counter in the 74xx library. Adds configurable width and modulus, up/down direction, synchronous parallel load, 74161-style dual count enables, a cascadable terminal-count output and a registered wrap pulse. Used wherever the library needs a presettable divider or a cascaded event counter in a single clock domain.

## Interface

- WIDTH, 12, counter width in bits; legal range 2..32
- MODULUS, 4096, count range 0..MODULUS-1; legal range 2..2**WIDTH
- clk  input  1  clock; all state updates on the rising edge
- clr  input  1  synchronous, active-high reset; highest priority
- load  input  1  synchronous parallel load of d; overrides counting
- d  input  WIDTH  parallel load value
- cep  input  1  count enable, parallel; gates counting only
- cet  input  1  count enable, trickle; gates counting and tc
- up  input  1  direction: 1 counts up, 0 counts down
- q  output  WIDTH  counter state, registered
- tc  output  1  terminal count, combinational, for cascading into the next stage's cet
- wrap  output  1  registered one-cycle pulse: the previous edge wrapped the count

Clocking and reset (decided): one clock; reset is synchronous and active-high.

## Operation

- Per rising edge of clk, priority clr > load > count > hold.
- clr=1: q <= 0, wrap <= 0; load, cep, cet and up are ignored.
- load=1 (clr=0): q <= d if d < MODULUS, else q <= MODULUS-1 (saturate); ignores cep/cet; wrap <= 0.
- Count (clr=0, load=0, cep=1, cet=1):
  - up=1: q <= (q >= MODULUS-1) ? 0 : q+1; wrap <= (q >= MODULUS-1).
  - up=0: q <= (q == 0) ? MODULUS-1 : q-1; wrap <= (q == 0).
- Hold (any enable low): q unchanged, wrap <= 0.
- tc = cet & (up ? (q == MODULUS-1) : (q == 0)); independent of cep, load and clr.
- Arithmetic is WIDTH bits, unsigned; no intermediate overflow. With MODULUS = 2**WIDTH, wrap coincides with natural binary rollover.
- Direction change takes effect on the next edge; no state is lost.
- q outside 0..MODULUS-1 is unreachable after clr or load. Power-up X is cleared by one clr edge.

## Timing

- Reset values, after one clr edge: q = 0, wrap = 0; tc = cet & ~up.
- Latency: q and wrap reflect inputs sampled at the edge, valid one clock after the edge. No combinational path from d, load, cep or clr to any output.
- tc is combinational from q, cet and up: zero-cycle cascade path. N cascaded stages count as one WIDTH*N counter when all share clk and cep and each stage's cet = the previous stage's tc.
- wrap is high for exactly one cycle per wrap. Consecutive wraps (MODULUS=2) give wrap high on each counting cycle.
- clr or load asserted in the same cycle as a would-be wrap: no wrap pulse; clr/load wins.
- Reset mid-count: the next edge yields q=0 regardless of direction or enables.

## Test plan

- Reset/idle: WIDTH=12, MODULUS=4096. Hold clr=1 for 2 edges with cep=cet=up=1 -> q=0, wrap=0, tc=0. Release clr with cep=0 for 3 edges -> q stays 0.
- Full up-count: defaults, cep=cet=up=1, 4096 edges from 0 -> q increments by 1 each edge. tc=1 only while q=4095. Edge 4096 gives q=0 with wrap=1 for exactly one cycle.
- Modulus/down: WIDTH=4, MODULUS=10, up=0 from q=0 -> sequence 9,8,...,0,9. wrap pulses after the 0->9 step. tc=1 only at q=0 with cet=1.
- Load priority and saturation: WIDTH=4, MODULUS=10. load=1, d=7, cep=cet=1 -> q=7, no increment. d=13 -> q=9. clr=1 with load=1, d=5 -> q=0.
- Enables: cep=0, cet=1 at q=9, up=1 -> q holds 9, tc=1. cet=0 -> tc=0, q holds. Toggle up at q=5 -> the next edges give 6 then 5.
- Cascade: two WIDTH=4 instances, MODULUS=16, stage1.cet = stage0.tc, shared cep=1 -> combined {q1,q0} counts 0..255 and wraps to 0. stage1.wrap pulses once per 256 edges.
